// File: rtl/lfsr_stream_checker.sv
// -----------------------------------------------------------------------------
// lfsr_stream_checker
//
// AXI-Stream sink that checks incoming packets against an 8-bit LFSR pattern.
// After a START pulse the checker raises TREADY and compares each accepted
// beat with the zero-extended LFSR value, the expected TDEST and the expected
// TLAST position. A packet containing a bad beat is counted in ERR_CNT and the
// rest of it is drained unchecked. A clean packet is counted in PKT_CNT.
//
// Parameters
//   TDATAW       stream data width
//   TDESTW       stream destination width
//   LFSR_DW      LFSR width (fixed at 8; taps are hard-wired)
//   LFSR_DEFAULT LFSR seed, reloaded on every START (must be non-zero)
//   PKT_LEN      beats per packet, 1..255
//   MY_DEST      TDEST value every beat must carry
//
// Ports
//   CLK            single clock
//   RST_N          asynchronous active-low reset
//   START          arm pulse, honoured only in IDLE
//   AXIS_S_TVALID  stream beat valid
//   AXIS_S_TREADY  stream ready (high in RECV and DRAIN)
//   AXIS_S_TDATA   stream data
//   AXIS_S_TLAST   end-of-packet marker
//   AXIS_S_TDEST   stream destination
//   PKT_CNT        good packets, saturating
//   ERR_CNT        bad packets, saturating
//   ERR            sticky error flag, set by the first bad beat
//   ERR_DATA       TDATA of the first bad beat
//   BUSY           checker is armed (state != IDLE)
//
// Build option
//   CHECKER_BACKPRESSURE_EN  gates TREADY with a free-running toggle so that
//                            upstream sees a stall on every other cycle.
// -----------------------------------------------------------------------------
module lfsr_stream_checker #(
  parameter int                 TDATAW       = 32,
  parameter int                 TDESTW       = 4,
  parameter int                 LFSR_DW      = 8,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 8'h01,
  parameter int                 PKT_LEN      = 4,
  parameter int                 MY_DEST      = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic [15:0]       PKT_CNT,
  output logic [15:0]       ERR_CNT,
  output logic              ERR,
  output logic [TDATAW-1:0] ERR_DATA,
  output logic              BUSY
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [7:0]        LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [TDESTW-1:0] DEST_EXP = TDESTW'(MY_DEST);

  logic [1:0]         state;
  logic               ready_q;
  logic [LFSR_DW-1:0] lfsr;
  logic [LFSR_DW-1:0] lfsr_next;
  logic [7:0]         beat_idx;
  logic [7:0]         beat_idx_next;
  logic [TDATAW-1:0]  exp_data;
  logic               accept;
  logic               recv_beat;
  logic               beat_bad;

  // Handshake and per-beat expectations.
  assign accept    = AXIS_S_TVALID & AXIS_S_TREADY;
  assign recv_beat = accept & (state == RECV);
  assign exp_data  = TDATAW'(lfsr);
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // TLAST resets the beat position whether or not the packet was checked,
  // so DRAIN realigns to the next packet boundary.
  assign beat_idx_next = AXIS_S_TLAST ? 8'd0 : beat_idx + 8'd1;

  assign beat_bad = (AXIS_S_TDATA != exp_data)                    |
                    (AXIS_S_TDEST != DEST_EXP)                    |
                    ( AXIS_S_TLAST && (beat_idx <  LAST_IDX))     |
                    (!AXIS_S_TLAST && (beat_idx == LAST_IDX));

  assign BUSY = (state != IDLE);

  // Stream ready: a registered "armed" flag, optionally gated by a toggle.
`ifdef CHECKER_BACKPRESSURE_EN
  logic bp_toggle;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) bp_toggle <= 1'b1;
    else        bp_toggle <= ~bp_toggle;
  end

  assign AXIS_S_TREADY = ready_q & bp_toggle;
`else
  assign AXIS_S_TREADY = ready_q;
`endif

  // Control path: FSM, LFSR and beat position.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values and the block behaves the same regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      lfsr     <= LFSR_DEFAULT;
      beat_idx <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state    <= RECV;
            ready_q  <= 1'b1;
            lfsr     <= LFSR_DEFAULT;
            beat_idx <= 8'd0;
          end
        end
        RECV: begin
          if (accept) begin
            lfsr     <= lfsr_next;
            beat_idx <= beat_idx_next;
            // A bad beat that is also the last one closes the packet itself;
            // otherwise the remainder must be skipped up to TLAST.
            if (beat_bad && !AXIS_S_TLAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept) begin
            lfsr     <= lfsr_next;
            beat_idx <= beat_idx_next;
            if (AXIS_S_TLAST) state <= RECV;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Status path: counters and the sticky error capture. A bad beat always
  // leaves RECV or ends the packet, so a TLAST beat reaching here clean means
  // the whole packet was clean.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PKT_CNT  <= 16'd0;
      ERR_CNT  <= 16'd0;
      ERR      <= 1'b0;
      ERR_DATA <= '0;
    end else if (recv_beat) begin
      if (beat_bad) begin
        if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
        if (!ERR) begin
          ERR      <= 1'b1;
          ERR_DATA <= AXIS_S_TDATA;
        end
      end else if (AXIS_S_TLAST) begin
        if (PKT_CNT != 16'hFFFF) PKT_CNT <= PKT_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream_checker
//
// Directed bench for lfsr_stream_checker with default parameters (seed 01,
// PKT_LEN 4, MY_DEST 0). Each scenario task drives its own stimulus and
// compares DUT outputs with hand-computed values. Inputs change and outputs
// are sampled on the falling clock edge.
//
// LFSR sequence from seed 01, next = {l[6:0], l7^l5^l4^l3}:
//   01 02 04 08 11 23 47 8E 1C 38 71 E2 C4 89 12 25
// -----------------------------------------------------------------------------
module tb_lfsr_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic [3:0]  tdest = '0;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic        err;
  logic [31:0] err_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                           8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25};

  always #5 clk = ~clk;

  lfsr_stream_checker dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .START         (start),
    .AXIS_S_TVALID (tvalid),
    .AXIS_S_TREADY (tready),
    .AXIS_S_TDATA  (tdata),
    .AXIS_S_TLAST  (tlast),
    .AXIS_S_TDEST  (tdest),
    .PKT_CNT       (pkt_cnt),
    .ERR_CNT       (err_cnt),
    .ERR           (err),
    .ERR_DATA      (err_data),
    .BUSY          (busy)
  );

  // ---------------------------------------------------------------- helpers
  // All helpers start and end on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tvalid = 1'b0; start = 1'b0; tlast = 1'b0; tdest = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one beat and hold it until the handshake edge has passed.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic [3:0] dest);
    int waited = 0;
    tvalid = 1'b1; tdata = d; tlast = last; tdest = dest;
    while (!tready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL beat_handshake_timeout: tready=%b after %0d cycles, want 1", tready, waited);
    end
    @(negedge clk);
  endtask

  task automatic end_burst();
    tvalid = 1'b0; tlast = 1'b0; tdest = '0;
  endtask

  // Four correct beats taken from the LFSR table starting at 'base'.
  task automatic send_good(input int base);
    for (int i = 0; i < 4; i++) send_beat({24'd0, seq[base+i]}, (i == 3), 4'd0);
    end_burst();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (tready  !== 1'b0)  begin errors++; $display("FAIL rst_tready: got %b want 0", tready); end
    checks++; if (busy    !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    checks++; if (err     !== 1'b0)  begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (err_data !== 32'd0) begin errors++; $display("FAIL rst_err_data: got %h want 0", err_data); end
    do_reset();
  endtask

  task automatic test_idle_no_accept();
    do_reset();
    tvalid = 1'b1; tdata = 32'h01; tlast = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tready  !== 1'b0)  begin errors++; $display("FAIL idle_tready: got %b want 0", tready); end
    checks++; if (busy    !== 1'b0)  begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL idle_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL idle_err_cnt: got %0d want 0", err_cnt); end
    end_burst();
  endtask

  task automatic test_good_packets();
    do_reset();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
`ifndef CHECKER_BACKPRESSURE_EN
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL start_tready: got %b want 1", tready); end
`endif
    send_good(0);
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL good1_pkt_cnt: got %0d want 1", pkt_cnt); end
    checks++; if (err     !== 1'b0)  begin errors++; $display("FAIL good1_err: got %b want 0", err); end
    send_good(4);
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL good2_pkt_cnt: got %0d want 2", pkt_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL good2_err_cnt: got %0d want 0", err_cnt); end
    // START while receiving must not reload the LFSR.
    pulse_start();
    send_good(8);
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL start_ignored_pkt_cnt: got %0d want 3", pkt_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL start_ignored_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_bad_data();
    do_reset();
    pulse_start();
    send_beat(32'h01, 1'b0, 4'd0);
    send_beat(32'h02, 1'b0, 4'd0);
    send_beat(32'h05, 1'b0, 4'd0);
    checks++; if (err      !== 1'b1)   begin errors++; $display("FAIL bad_err: got %b want 1", err); end
    checks++; if (err_data !== 32'h05) begin errors++; $display("FAIL bad_err_data: got %h want 05", err_data); end
    checks++; if (err_cnt  !== 16'd1)  begin errors++; $display("FAIL bad_err_cnt: got %0d want 1", err_cnt); end
    // Drain beat: unchecked, ends the bad packet.
    send_beat(32'hFF, 1'b1, 4'd0);
    end_burst();
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL drain_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL drain_err_cnt: got %0d want 1", err_cnt); end
    send_good(4);
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL after_drain_pkt_cnt: got %0d want 1", pkt_cnt); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL after_drain_err_cnt: got %0d want 1", err_cnt); end
    // Second bad packet: counted, but ERR_DATA keeps the first offender.
    send_beat(32'h1C, 1'b0, 4'd0);
    send_beat(32'h38, 1'b0, 4'd0);
    send_beat(32'h99, 1'b0, 4'd0);
    send_beat(32'h77, 1'b1, 4'd0);
    end_burst();
    checks++; if (err_cnt  !== 16'd2)  begin errors++; $display("FAIL bad2_err_cnt: got %0d want 2", err_cnt); end
    checks++; if (err_data !== 32'h05) begin errors++; $display("FAIL bad2_err_data: got %h want 05", err_data); end
  endtask

  task automatic test_tlast_position();
    do_reset();
    pulse_start();
    // TLAST on the second beat of a four-beat packet.
    send_beat(32'h01, 1'b0, 4'd0);
    send_beat(32'h02, 1'b1, 4'd0);
    end_burst();
    checks++; if (err_cnt  !== 16'd1)  begin errors++; $display("FAIL early_err_cnt: got %0d want 1", err_cnt); end
    checks++; if (err_data !== 32'h02) begin errors++; $display("FAIL early_err_data: got %h want 02", err_data); end
    checks++; if (busy     !== 1'b1)   begin errors++; $display("FAIL early_busy: got %b want 1", busy); end
    // Still in RECV with beat index 0: next packet checks clean.
    send_good(2);
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL early_next_pkt_cnt: got %0d want 1", pkt_cnt); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL early_next_err_cnt: got %0d want 1", err_cnt); end
    // Missing TLAST on the fourth beat, then a drain beat carrying TLAST.
    for (int i = 6; i < 10; i++) send_beat({24'd0, seq[i]}, 1'b0, 4'd0);
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL missing_last_err_cnt: got %0d want 2", err_cnt); end
    send_beat(32'h00, 1'b1, 4'd0);
    end_burst();
    send_good(11);
    checks++; if (pkt_cnt !== 16'd2) begin errors++; $display("FAIL missing_next_pkt_cnt: got %0d want 2", pkt_cnt); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL missing_next_err_cnt: got %0d want 2", err_cnt); end
  endtask

  task automatic test_bad_dest();
    do_reset();
    pulse_start();
    send_beat(32'h01, 1'b0, 4'd1);
    checks++; if (err      !== 1'b1)   begin errors++; $display("FAIL dest_err: got %b want 1", err); end
    checks++; if (err_cnt  !== 16'd1)  begin errors++; $display("FAIL dest_err_cnt: got %0d want 1", err_cnt); end
    checks++; if (err_data !== 32'h01) begin errors++; $display("FAIL dest_err_data: got %h want 01", err_data); end
    send_beat(32'h00, 1'b0, 4'd0);
    send_beat(32'h00, 1'b0, 4'd0);
    send_beat(32'h00, 1'b1, 4'd0);
    end_burst();
    send_good(4);
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL dest_next_pkt_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    pulse_start();
    // A bad-TLAST packet and a good one so every status output is non-zero.
    send_beat(32'h01, 1'b0, 4'd0);
    send_beat(32'h02, 1'b0, 4'd0);
    send_beat(32'h04, 1'b0, 4'd0);
    send_beat(32'h09, 1'b1, 4'd0);
    end_burst();
    send_good(4);
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL pre_rst_pkt_cnt: got %0d want 1", pkt_cnt); end
    checks++; if (err_data !== 32'h09) begin errors++; $display("FAIL pre_rst_err_data: got %h want 09", err_data); end
    send_beat(32'h1C, 1'b0, 4'd0);
    send_beat(32'h38, 1'b0, 4'd0);
    end_burst();
    // Assert reset between clock edges; outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tready   !== 1'b0)  begin errors++; $display("FAIL mid_rst_tready: got %b want 0", tready); end
    checks++; if (busy     !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (pkt_cnt  !== 16'd0) begin errors++; $display("FAIL mid_rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (err_cnt  !== 16'd0) begin errors++; $display("FAIL mid_rst_err_cnt: got %0d want 0", err_cnt); end
    checks++; if (err      !== 1'b0)  begin errors++; $display("FAIL mid_rst_err: got %b want 0", err); end
    checks++; if (err_data !== 32'd0) begin errors++; $display("FAIL mid_rst_err_data: got %h want 0", err_data); end
    @(negedge clk);
    rst_n = 1'b1;
    // Without a new START nothing is accepted.
    tvalid = 1'b1; tdata = 32'h01; tlast = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tready  !== 1'b0)  begin errors++; $display("FAIL post_rst_tready: got %b want 0", tready); end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL post_rst_pkt_cnt: got %0d want 0", pkt_cnt); end
    end_burst();
    pulse_start();
    send_good(0);
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_good_pkt_cnt: got %0d want 1", pkt_cnt); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL post_rst_good_err_cnt: got %0d want 0", err_cnt); end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_idle_no_accept();
    test_good_packets();
    test_bad_data();
    test_tlast_position();
    test_bad_dest();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
